// File: rtl/clock_pkg.sv
// Shared definitions for the clock adjust path: FSM encoding, repeat direction
// and the 50 MHz timing defaults used by every adjustable field.
package clock_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DELAY,
      ST_REPEAT,
      ST_LOCK
   } adj_state_t;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } adj_dir_t;

   localparam int DEB_CYCLES_50M   = 1_000_000;   // 20 ms
   localparam int DELAY_CYCLES_50M = 25_000_000;  // 500 ms
   localparam int RATE_CYCLES_50M  = 5_000_000;   // 100 ms

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a stable-level debouncer for one raw
// push-button; the stable level moves only after DEB_CYCLES agreeing samples.
module btn_debounce
   import clock_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_50M
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic stable
);

   localparam int               CNT_W    = $clog2(DEB_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      // NOTE: every signal gets its default before any branch, so no path can infer a latch.
      sync1_d  = btn_raw;
      sync2_d  = sync1_q;
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // btn_raw is asynchronous: only sync1_q may go metastable, sync2_q is the clean sample.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign stable = stable_q;

endmodule

// File: rtl/adj_button_ctrl.sv
// Turns the debounced add/reduce buttons into single-cycle step pulses with
// hold-to-repeat; pressing both buttons locks out stepping until both are released.
module adj_button_ctrl
   import clock_pkg::*;
#(
   parameter int DEB_CYCLES   = DEB_CYCLES_50M,
   parameter int DELAY_CYCLES = DELAY_CYCLES_50M,
   parameter int RATE_CYCLES  = RATE_CYCLES_50M
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_add,
   input  logic btn_reduce,
   output logic step_up,
   output logic step_down,
   output logic held_add,
   output logic held_reduce
);

   localparam int                 TIMER_W    = $clog2(max3(DEB_CYCLES, DELAY_CYCLES, RATE_CYCLES));
   localparam logic [TIMER_W-1:0] DELAY_LAST = TIMER_W'(DELAY_CYCLES - 1);
   localparam logic [TIMER_W-1:0] RATE_LAST  = TIMER_W'(RATE_CYCLES - 1);

   adj_state_t         state_q, state_d;
   adj_dir_t           dir_q, dir_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic               step_up_q, step_up_d;
   logic               step_down_q, step_down_d;
   logic               pulse;
   logic               active_held, other_held;

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_add (
      .clk     (clk),
      .rst_n   (reset),
      .btn_raw (btn_add),
      .stable  (held_add)
   );

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_reduce (
      .clk     (clk),
      .rst_n   (reset),
      .btn_raw (btn_reduce),
      .stable  (held_reduce)
   );

   assign active_held = (dir_q == DIR_UP) ? held_add : held_reduce;
   assign other_held  = (dir_q == DIR_UP) ? held_reduce : held_add;

   // Release and lock are tested before timer expiry, so a release never yields a pulse.
   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      timer_d = timer_q;
      pulse   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (held_add && held_reduce) begin
               state_d = ST_LOCK;
            end else if (held_add || held_reduce) begin
               dir_d   = held_add ? DIR_UP : DIR_DOWN;
               pulse   = 1'b1;
               timer_d = '0;
               state_d = ST_DELAY;
            end
         end
         ST_DELAY, ST_REPEAT: begin
            if (other_held) begin
               state_d = ST_LOCK;
               timer_d = '0;
            end else if (!active_held) begin
               state_d = ST_IDLE;
               timer_d = '0;
            end else if (timer_q == ((state_q == ST_DELAY) ? DELAY_LAST : RATE_LAST)) begin
               pulse   = 1'b1;
               timer_d = '0;
               state_d = ST_REPEAT;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ST_LOCK: begin
            if (!held_add && !held_reduce) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      step_up_d   = pulse && (dir_d == DIR_UP);
      step_down_d = pulse && (dir_d == DIR_DOWN);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         dir_q       <= DIR_UP;
         timer_q     <= '0;
         step_up_q   <= 1'b0;
         step_down_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         dir_q       <= dir_d;
         timer_q     <= timer_d;
         step_up_q   <= step_up_d;
         step_down_q <= step_down_d;
      end
   end

   assign step_up   = step_up_q;
   assign step_down = step_down_q;

endmodule

// File: tb/tb_adj_button_ctrl.sv
// Scoreboard bench for adj_button_ctrl: directed scenarios plus random presses,
// checked against a cycle-indexed behavioural model of the button rules.
module tb_adj_button_ctrl;

   localparam int DEB   = 4;
   localparam int DELAY = 20;
   localparam int RATE  = 8;
   localparam int N     = 4096;

   localparam int M_FREE = 0;
   localparam int M_HOLD = 1;
   localparam int M_LOCK = 2;

   typedef struct {
      int cyc;
      bit up;
   } exp_t;

   logic clk;
   logic reset;
   logic btn_add;
   logic btn_reduce;
   logic step_up;
   logic step_down;
   logic held_add;
   logic held_reduce;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int obs_up   = 0;
   int obs_down = 0;
   bit prev_pulse = 1'b0;

   exp_t exp_q[$];
   bit   raw_a[N];
   bit   raw_r[N];
   bit   rst_h[N];
   bit   samp_a[N];
   bit   samp_r[N];
   bit   exp_ha[N];
   bit   exp_hr[N];

   int m_mode = M_FREE;
   int m_ps   = 0;
   bit m_up   = 1'b0;
   bit m_held_a = 1'b0;
   bit m_held_r = 1'b0;

   adj_button_ctrl #(
      .DEB_CYCLES   (DEB),
      .DELAY_CYCLES (DELAY),
      .RATE_CYCLES  (RATE)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .btn_add     (btn_add),
      .btn_reduce  (btn_reduce),
      .step_up     (step_up),
      .step_down   (step_down),
      .held_add    (held_add),
      .held_reduce (held_reduce)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // The synchronizer output seen at edge t is the raw level of edge t-2,
   // forced low if reset was active on either of the two preceding edges.
   function automatic bit sync_blocked(input int t);
      if (t < 3) return 1'b1;
      return rst_h[t-1] || rst_h[t-2];
   endfunction

   // A held level flips once the last DEB synchronized samples all disagree with it.
   function automatic bit flips(input int t, input bit is_r, input bit cur);
      for (int j = 0; j < DEB; j++) begin
         if (t - j < 1) return 1'b0;
         if ((is_r ? samp_r[t-j] : samp_a[t-j]) == cur) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic model_step(input int t, input bit a, input bit r, input bit rs);
      bit ha, hr, act, oth, pulse;
      int k;
      raw_a[t] = a;
      raw_r[t] = r;
      rst_h[t] = rs;
      if (sync_blocked(t)) begin
         samp_a[t] = 1'b0;
         samp_r[t] = 1'b0;
      end else begin
         samp_a[t] = raw_a[t-2];
         samp_r[t] = raw_r[t-2];
      end
      ha    = m_held_a;
      hr    = m_held_r;
      pulse = 1'b0;
      if (rs) begin
         m_mode = M_FREE;
      end else begin
         case (m_mode)
            M_FREE: begin
               if (ha && hr) begin
                  m_mode = M_LOCK;
               end else if (ha || hr) begin
                  m_mode = M_HOLD;
                  m_up   = ha;
                  m_ps   = t;
                  pulse  = 1'b1;
               end
            end
            M_HOLD: begin
               act = m_up ? ha : hr;
               oth = m_up ? hr : ha;
               if (oth) begin
                  m_mode = M_LOCK;
               end else if (!act) begin
                  m_mode = M_FREE;
               end else begin
                  k     = t - m_ps;
                  pulse = (k == DELAY) || (k > DELAY && ((k - DELAY) % RATE) == 0);
               end
            end
            default: begin
               if (!ha && !hr) m_mode = M_FREE;
            end
         endcase
      end
      if (rs) begin
         m_held_a = 1'b0;
         m_held_r = 1'b0;
      end else begin
         if (flips(t, 1'b0, m_held_a)) m_held_a = !m_held_a;
         if (flips(t, 1'b1, m_held_r)) m_held_r = !m_held_r;
      end
      exp_ha[t] = m_held_a;
      exp_hr[t] = m_held_r;
      if (pulse) exp_q.push_back('{cyc: t, up: m_up});
   endtask

   // One clock of stimulus: inputs land 1 time unit after an edge; reset asserts
   // after the monitor's sample so the next observation already reflects it.
   task automatic cycle(input bit a, input bit r, input bit rs);
      int t;
      t = cyc + 1;
      if (t >= N) begin
         $display("FAIL cycle_budget: t=%0d limit=%0d", t, N);
         $fatal(1, "stimulus exceeded model storage");
      end
      btn_add    = a;
      btn_reduce = r;
      if (rs && reset) begin
         @(negedge clk);
         #1 reset = 1'b0;
         #1;
         check("rst_async_step_up", step_up, 0);
         check("rst_async_step_down", step_down, 0);
         check("rst_async_held_add", held_add, 0);
         check("rst_async_held_reduce", held_reduce, 0);
      end else if (!rs && !reset) begin
         reset = 1'b1;
      end
      model_step(t, a, r, rs);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
   endtask

   always @(negedge clk) begin
      if (cyc > 0) begin
         check("held_add", held_add, exp_ha[cyc]);
         check("held_reduce", held_reduce, exp_hr[cyc]);
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            check("pulse_missing", cyc, exp_q[0].cyc);
            void'(exp_q.pop_front());
         end
         if (step_up || step_down) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
               check("pulse_dir_up", step_up, exp_q[0].up);
               void'(exp_q.pop_front());
            end else begin
               check("pulse_unexpected", cyc, (exp_q.size() > 0) ? exp_q[0].cyc : -1);
            end
            check("pulse_exclusive", step_up && step_down, 0);
            check("pulse_consecutive", prev_pulse, 0);
         end
         prev_pulse = step_up || step_down;
         if (step_up) obs_up++;
         if (step_down) obs_down++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int u0, d0;
      reset      = 1'b0;
      btn_add    = 1'b0;
      btn_reduce = 1'b0;
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1);
      check("reset_step_up", step_up, 0);
      check("reset_step_down", step_down, 0);
      check("reset_held_add", held_add, 0);
      check("reset_held_reduce", held_reduce, 0);
      idle(3);

      // 1: short add press, one pulse
      u0 = obs_up; d0 = obs_down;
      for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0);
      idle(15);
      check("t1_up_count", obs_up - u0, 1);
      check("t1_down_count", obs_down - d0, 0);

      // 2: long reduce hold, first pulse, delay, then repeat
      u0 = obs_up; d0 = obs_down;
      for (int i = 0; i < 60; i++) cycle(1'b0, 1'b1, 1'b0);
      idle(15);
      check("t2_up_count", obs_up - u0, 0);
      check("t2_down_count", obs_down - d0, 6);

      // 3: bouncing add shorter than the debounce window
      u0 = obs_up; d0 = obs_down;
      for (int i = 0; i < 30; i++) cycle(bit'(((i / 2) % 2) == 0), 1'b0, 1'b0);
      idle(15);
      check("t3_up_count", obs_up - u0, 0);

      // 4: both pressed together lock out, then a clean add press
      u0 = obs_up; d0 = obs_down;
      for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, 1'b0);
      idle(15);
      check("t4_locked_pulses", (obs_up - u0) + (obs_down - d0), 0);
      for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0);
      idle(15);
      check("t4_up_count", obs_up - u0, 1);
      check("t4_down_count", obs_down - d0, 0);

      // 5: reduce joins during the add delay; lock holds while add stays pressed
      u0 = obs_up; d0 = obs_down;
      for (int i = 0; i < 15; i++) cycle(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 30; i++) cycle(1'b1, 1'b0, 1'b0);
      idle(15);
      check("t5_up_count", obs_up - u0, 1);
      check("t5_down_count", obs_down - d0, 0);

      // 6: reset in the middle of a hold, press re-qualifies afterwards
      u0 = obs_up; d0 = obs_down;
      for (int i = 0; i < 29; i++) cycle(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 1'b0);
      idle(15);
      check("t6_up_count", obs_up - u0, 3);
      check("t6_down_count", obs_down - d0, 0);

      // Random presses, bounces, overlaps and occasional resets
      for (int s = 0; s < 24; s++) begin
         int kind;
         int len;
         bit a;
         bit r;
         bit rs;
         kind = $urandom_range(0, 4);
         len  = $urandom_range(1, 45);
         for (int i = 0; i < len; i++) begin
            case (kind)
               0:       begin a = 1'b1; r = 1'b0; end
               1:       begin a = 1'b0; r = 1'b1; end
               2:       begin a = 1'b1; r = 1'b1; end
               3:       begin a = bit'($urandom_range(0, 1)); r = bit'($urandom_range(0, 1)); end
               default: begin a = 1'b1; r = (i > len / 2); end
            endcase
            rs = ((s % 6) == 5) && (i >= len / 2) && (i < len / 2 + 2);
            cycle(a, r, rs);
         end
         idle($urandom_range(3, 14));
      end

      idle(20);
      @(negedge clk);
      #1;
      check("queue_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
